// File: rtl/alu_op_decoder.sv
// Registered MIPS instruction decoder with a 2-entry skid (output reg + skid reg) on valid/ready.
// Optional macro ALU_DEC_ILLEGAL_TRAP_EN: flag unrecognised encodings on the illegal output.
module alu_op_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  op,
  output logic [4:0]  shamt,
  output logic [31:0] imm_ext,
  output logic        use_imm,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  dest,
  output logic        reg_we,
  output logic        illegal
);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_MULTS = 5'd2,  OP_MULTU = 5'd3;
  localparam logic [4:0] OP_AND  = 5'd4,  OP_SRL  = 5'd5,  OP_SRA   = 5'd6,  OP_SLT   = 5'd7;
  localparam logic [4:0] OP_BGT  = 5'd8,  OP_BLTE = 5'd9,  OP_OR    = 5'd10, OP_XOR   = 5'd11;
  localparam logic [4:0] OP_BEQ  = 5'd12, OP_BNE  = 5'd13, OP_BLT   = 5'd14, OP_BGTE  = 5'd15;
  localparam logic [4:0] OP_SLL  = 5'd16, OP_JA   = 5'd17, OP_JAL   = 5'd18, OP_JR    = 5'd19;
  localparam logic [4:0] OP_MFHI = 5'd20, OP_MFLO = 5'd21, OP_SLTU  = 5'd22, OP_SW    = 5'd23;
  localparam logic [4:0] OP_LW   = 5'd24;

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  shamt;
    logic [31:0] imm_ext;
    logic        use_imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic        reg_we;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] w);
    dec_t               d;
    logic               we;
    logic               known;
    logic signed [15:0] imm16;
    logic signed [31:0] sext;
    imm16 = w[15:0];
    sext  = imm16;
    d.op      = OP_ADD;
    d.shamt   = 5'd0;
    d.imm_ext = sext;
    d.use_imm = 1'b0;
    d.rs      = w[25:21];
    d.rt      = w[20:16];
    d.dest    = 5'd0;
    d.illegal = 1'b0;
    we        = 1'b0;
    known     = 1'b1;
    case (w[31:26])
      6'h00: begin
        d.dest = w[15:11];
        we     = 1'b1;
        case (w[5:0])
          6'h20, 6'h21: d.op = OP_ADD;
          6'h22, 6'h23: d.op = OP_SUB;
          6'h18: begin d.op = OP_MULTS; we = 1'b0; end
          6'h19: begin d.op = OP_MULTU; we = 1'b0; end
          6'h24: d.op = OP_AND;
          6'h25: d.op = OP_OR;
          6'h26: d.op = OP_XOR;
          6'h2A: d.op = OP_SLT;
          6'h2B: d.op = OP_SLTU;
          6'h00: begin d.op = OP_SLL; d.shamt = w[10:6]; end
          6'h02: begin d.op = OP_SRL; d.shamt = w[10:6]; end
          6'h03: begin d.op = OP_SRA; d.shamt = w[10:6]; end
          6'h08: begin d.op = OP_JR; we = 1'b0; end
          6'h10: d.op = OP_MFHI;
          6'h12: d.op = OP_MFLO;
          default: known = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin d.op = OP_ADD;  d.use_imm = 1'b1; d.dest = w[20:16]; we = 1'b1; end
      6'h0A:        begin d.op = OP_SLT;  d.use_imm = 1'b1; d.dest = w[20:16]; we = 1'b1; end
      6'h0B:        begin d.op = OP_SLTU; d.use_imm = 1'b1; d.dest = w[20:16]; we = 1'b1; end
      // Logical immediates are zero-extended, unlike every other I-type.
      6'h0C: begin d.op = OP_AND; d.imm_ext = {16'd0, w[15:0]}; d.use_imm = 1'b1; d.dest = w[20:16]; we = 1'b1; end
      6'h0D: begin d.op = OP_OR;  d.imm_ext = {16'd0, w[15:0]}; d.use_imm = 1'b1; d.dest = w[20:16]; we = 1'b1; end
      6'h0E: begin d.op = OP_XOR; d.imm_ext = {16'd0, w[15:0]}; d.use_imm = 1'b1; d.dest = w[20:16]; we = 1'b1; end
      6'h04: d.op = OP_BEQ;
      6'h05: d.op = OP_BNE;
      6'h06: d.op = OP_BLTE;
      6'h07: d.op = OP_BGT;
      6'h01: begin
        if (w[20:16] == 5'd0)      d.op = OP_BLT;
        else if (w[20:16] == 5'd1) d.op = OP_BGTE;
        else                       known = 1'b0;
      end
      6'h23: begin d.op = OP_LW; d.use_imm = 1'b1; d.dest = w[20:16]; we = 1'b1; end
      6'h2B: begin d.op = OP_SW; d.use_imm = 1'b1; end
      6'h02: begin d.op = OP_JA;  d.imm_ext = {6'd0, w[25:0]}; end
      6'h03: begin d.op = OP_JAL; d.imm_ext = {6'd0, w[25:0]}; d.dest = 5'd31; we = 1'b1; end
      default: known = 1'b0;
    endcase
    if (!known) begin
      d.op      = OP_ADD;
      d.shamt   = 5'd0;
      d.use_imm = 1'b0;
      d.dest    = 5'd0;
      we        = 1'b0;
    end
`ifdef ALU_DEC_ILLEGAL_TRAP_EN
    d.illegal = !known;
`else
    d.illegal = 1'b0;
`endif
    d.reg_we = we && (d.dest != 5'd0);
    return d;
  endfunction

  dec_t dec_p0;
  dec_t bnd_p1;
  dec_t skd_p1;
  logic vld_p1;
  logic skd_vld_p1;
  logic accept;
  logic out_free;

  always_comb begin
    dec_p0   = decode(instr);
    accept   = in_valid && in_ready;
    out_free = !vld_p1 || out_ready;
  end

  assign in_ready = !skd_vld_p1;

  // Stage p0 -> p1: output register refills from skid first to keep FIFO order.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      skd_vld_p1 <= 1'b0;
      bnd_p1     <= '0;
    end else if (out_free) begin
      if (skd_vld_p1) begin
        bnd_p1     <= skd_p1;
        vld_p1     <= 1'b1;
        skd_vld_p1 <= 1'b0;
      end else begin
        vld_p1 <= accept;
        if (accept) bnd_p1 <= dec_p0;
      end
    end else if (accept) begin
      skd_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!out_free && accept) skd_p1 <= dec_p0;
  end

  assign out_valid = vld_p1;
  assign op        = bnd_p1.op;
  assign shamt     = bnd_p1.shamt;
  assign imm_ext   = bnd_p1.imm_ext;
  assign use_imm   = bnd_p1.use_imm;
  assign rs        = bnd_p1.rs;
  assign rt        = bnd_p1.rt;
  assign dest      = bnd_p1.dest;
  assign reg_we    = bnd_p1.reg_we;
  assign illegal   = bnd_p1.illegal;

endmodule
